// File: rtl/mem_resp.sv
// Main-memory target for the KS10 backplane bus: samples a request, waits a
// programmable number of states, then answers with a one-clock ACK or NXM pulse.
module mem_resp #(
    parameter int memAW   = 10,
    parameter int memWAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clken,
    input  logic         busREQI,
    input  logic [0:35]  busADDRI,
    input  logic [0:35]  busDATAI,
    output logic         busACKO,
    output logic [0:35]  busDATAO,
    output logic         busNXM,
    output logic [14:35] nxmADDR,
    output logic         memBUSY
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [3:0] WAIT_LOAD = 4'(memWAIT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [21:0]       addr_q, addr_d;
    logic [35:0]       data_q, data_d;
    logic              ack_q, ack_d, nxm_q, nxm_d;
    logic              dout_en_q, dout_en_d;
    logic [21:0]       nxm_addr_q, nxm_addr_d;
    logic [35:0]       rdata_q;
    logic [35:0]       mem_q [0:(2**memAW)-1];

    logic              addr_ok;
    logic              resp_go;
    logic [memAW-1:0]  mem_idx;
    logic              unused_flags;

    assign unused_flags = ^{busADDRI[0:2], busADDRI[4], busADDRI[6:9], busADDRI[11:13]};

    assign addr_ok = ((addr_q >> memAW) == 22'd0);
    assign mem_idx = addr_q[memAW-1:0];
    assign resp_go = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ack_d      = 1'b0;
        nxm_d      = 1'b0;
        dout_en_d  = 1'b0;
        nxm_addr_d = nxm_addr_q;
        case (state_q)
            ST_IDLE: begin
                // IO cycles belong to the bridge; leave them untouched.
                if (busREQI && !busADDRI[10]) begin
                    rd_d    = busADDRI[3];
                    wr_d    = busADDRI[5];
                    addr_d  = busADDRI[14:35];
                    data_d  = busDATAI;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    if (addr_ok) begin
                        ack_d     = 1'b1;
                        dout_en_d = rd_q;
                    end else begin
                        nxm_d      = 1'b1;
                        nxm_addr_d = addr_q;
                    end
                end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: if (!busREQI) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 22'd0;
            data_q     <= 36'd0;
            ack_q      <= 1'b0;
            nxm_q      <= 1'b0;
            dout_en_q  <= 1'b0;
            nxm_addr_q <= 22'd0;
        end else if (clken) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            nxm_q      <= nxm_d;
            dout_en_q  <= dout_en_d;
            nxm_addr_q <= nxm_addr_d;
        end
    end

    // Read and write share the edge entering RESP, so a read-modify-write sees old data.
    always_ff @(posedge clk) begin
        if (clken && resp_go) begin
            rdata_q <= mem_q[mem_idx];
            if (wr_q && addr_ok) begin
                mem_q[mem_idx] <= data_q;
            end
        end
    end

    assign busACKO  = ack_q;
    assign busNXM   = nxm_q;
    assign busDATAO = dout_en_q ? rdata_q : 36'd0;
    assign nxmADDR  = nxm_addr_q;
    assign memBUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a word-array memory model.
module tb_mem_resp;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clken = 1'b1;
    logic         req1 = 1'b0, req0 = 1'b0;
    logic [0:35]  addr1 = '0, addr0 = '0, din1 = '0, din0 = '0;
    logic         ack1, ack0, nxm1, nxm0, busy1, busy0;
    logic [0:35]  dout1, dout0;
    logic [14:35] nxa1, nxa0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [21:0] exp_nxa1 = '0;

    mem_resp #(.memAW(10), .memWAIT(2)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .busREQI(req1), .busADDRI(addr1), .busDATAI(din1),
        .busACKO(ack1), .busDATAO(dout1), .busNXM(nxm1),
        .nxmADDR(nxa1), .memBUSY(busy1)
    );

    mem_resp #(.memAW(10), .memWAIT(0)) dut0 (
        .clk(clk), .rst(rst), .clken(clken),
        .busREQI(req0), .busADDRI(addr0), .busDATAI(din0),
        .busACKO(ack0), .busDATAO(dout0), .busNXM(nxm0),
        .nxmADDR(nxa0), .memBUSY(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'o%0o, expected 'o%0o", nm, act, exp);
        end
    endtask

    function automatic logic g_ack(input bit s);
        return s ? ack0 : ack1;
    endfunction
    function automatic logic g_nxm(input bit s);
        return s ? nxm0 : nxm1;
    endfunction
    function automatic logic g_busy(input bit s);
        return s ? busy0 : busy1;
    endfunction
    function automatic logic [35:0] g_dout(input bit s);
        return s ? dout0 : dout1;
    endfunction

    // One bus transaction: raise request, wait for a response (bounded), hold
    // the request a few more clocks, then drop it and let the DUT return to IDLE.
    task automatic txn(input bit sel0, input bit rd, input bit wr, input bit io,
                       input logic [21:0] a, input logic [35:0] d,
                       input int stall_len, input int limit,
                       output int lat, output bit r_ack, output bit r_nxm,
                       output logic [35:0] rdat, output bit pulse_ok,
                       output bit busy_seen, output bit busy_end);
        logic [0:35] aw;
        bit got;
        aw = '0;
        aw[3] = rd;
        aw[5] = wr;
        aw[10] = io;
        aw[14:35] = a;
        lat = -1; r_ack = 0; r_nxm = 0; rdat = '0;
        pulse_ok = 1; busy_seen = 0; got = 0;
        if (sel0) begin req0 = 1; addr0 = aw; din0 = d; end
        else      begin req1 = 1; addr1 = aw; din1 = d; end
        for (int t = 1; t <= limit && !got; t++) begin
            tick();
            if (t == 1 && stall_len > 0) begin
                clken = 1'b0;
                repeat (stall_len) tick();
                clken = 1'b1;
                t += stall_len;
            end
            if (g_busy(sel0)) busy_seen = 1;
            if (g_ack(sel0) || g_nxm(sel0)) begin
                got   = 1;
                lat   = t;
                r_ack = g_ack(sel0);
                r_nxm = g_nxm(sel0);
                rdat  = g_dout(sel0);
                if (r_ack && r_nxm) pulse_ok = 0;
            end
        end
        if (got) begin
            repeat (4) begin
                tick();
                if (g_ack(sel0) || g_nxm(sel0) || g_dout(sel0) != 36'd0) pulse_ok = 0;
            end
        end
        if (sel0) req0 = 0; else req1 = 0;
        tick();
        busy_end = g_busy(sel0);
    endtask

    task automatic run_check(input string nm, input bit sel0, input bit rd, input bit wr,
                             input bit io, input logic [21:0] a, input logic [35:0] d,
                             input int stall, input bit e_ack, input bit e_nxm,
                             input logic [35:0] e_dat, input int e_lat);
        int lat;
        bit r_ack, r_nxm, pulse_ok, busy_seen, busy_end;
        logic [35:0] rdat;
        txn(sel0, rd, wr, io, a, d, stall, io ? 20 : 60,
            lat, r_ack, r_nxm, rdat, pulse_ok, busy_seen, busy_end);
        $display("txn %s: rd=%0b wr=%0b io=%0b addr='o%0o lat=%0d ack=%0b nxm=%0b data='o%0o",
                 nm, rd, wr, io, a, lat, r_ack, r_nxm, rdat);
        chk({nm, "_lat"}, 36'(lat), 36'(e_lat));
        chk({nm, "_ack"}, 36'(r_ack), 36'(e_ack));
        chk({nm, "_nxm"}, 36'(r_nxm), 36'(e_nxm));
        chk({nm, "_data"}, rdat, e_dat);
        chk({nm, "_busy_seen"}, 36'(busy_seen), 36'(!io));
        chk({nm, "_busy_end"}, 36'(busy_end), 36'd0);
        if (!io) chk({nm, "_pulse"}, 36'(pulse_ok), 36'd1);
        if (!sel0) begin
            if (e_nxm) exp_nxa1 = a;
            chk({nm, "_nxmaddr"}, 36'(nxa1), 36'(exp_nxa1));
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [21:0] addr;
        logic [35:0] data;
        bit          e_ack;
        bit          e_nxm;
        logic [35:0] e_dat;
    } vec_t;

    vec_t vt[12];
    logic [35:0] mdl [0:15];

    initial begin
        vt[0]  = '{1'b0, 1'b1, 22'd5,     36'o123456701234, 1'b1, 1'b0, 36'o0};
        vt[1]  = '{1'b1, 1'b0, 22'd5,     36'o0,            1'b1, 1'b0, 36'o123456701234};
        vt[2]  = '{1'b0, 1'b1, 22'd7,     36'o1,            1'b1, 1'b0, 36'o0};
        vt[3]  = '{1'b1, 1'b1, 22'd7,     36'o2,            1'b1, 1'b0, 36'o1};
        vt[4]  = '{1'b1, 1'b0, 22'd7,     36'o0,            1'b1, 1'b0, 36'o2};
        vt[5]  = '{1'b0, 1'b1, 22'd0,     36'o5555,         1'b1, 1'b0, 36'o0};
        vt[6]  = '{1'b1, 1'b0, 22'o2000,  36'o0,            1'b0, 1'b1, 36'o0};
        vt[7]  = '{1'b0, 1'b1, 22'o2000,  36'o777,          1'b0, 1'b1, 36'o0};
        vt[8]  = '{1'b1, 1'b0, 22'd0,     36'o0,            1'b1, 1'b0, 36'o5555};
        vt[9]  = '{1'b0, 1'b0, 22'd5,     36'o7777,         1'b1, 1'b0, 36'o0};
        vt[10] = '{1'b1, 1'b0, 22'd5,     36'o0,            1'b1, 1'b0, 36'o123456701234};
        vt[11] = '{1'b0, 1'b1, 22'd3,     36'o3333,         1'b1, 1'b0, 36'o0};

        // Reset state
        #2 rst = 1'b0;
        #10;
        chk("rst_ack", 36'(ack1), 36'd0);
        chk("rst_nxm", 36'(nxm1), 36'd0);
        chk("rst_dout", dout1, 36'd0);
        chk("rst_nxa", 36'(nxa1), 36'd0);
        chk("rst_busy", 36'(busy1), 36'd0);
        #3 rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("vec%0d", i), 1'b0, vt[i].rd, vt[i].wr, 1'b0,
                      vt[i].addr, vt[i].data, 0,
                      vt[i].e_ack, vt[i].e_nxm, vt[i].e_dat, 4);
        end

        // IO cycle is ignored entirely
        run_check("io_ignored", 1'b0, 1'b1, 1'b0, 1'b1, 22'd5, 36'o0, 0,
                  1'b0, 1'b0, 36'o0, -1);

        // Reset while a write to addr 3 sits in WAIT
        req1 = 1'b1;
        addr1 = '0; addr1[5] = 1'b1; addr1[14:35] = 22'd3;
        din1 = 36'o4444;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        $display("txn rst_mid: write addr 3 abandoned, busy=%0b", busy1);
        chk("rstmid_ack", 36'(ack1), 36'd0);
        chk("rstmid_nxm", 36'(nxm1), 36'd0);
        chk("rstmid_dout", dout1, 36'd0);
        chk("rstmid_nxa", 36'(nxa1), 36'd0);
        chk("rstmid_busy", 36'(busy1), 36'd0);
        exp_nxa1 = '0;
        tick();
        req1 = 1'b0;
        #2 rst = 1'b1;
        tick();
        run_check("rst_readback", 1'b0, 1'b1, 1'b0, 1'b0, 22'd3, 36'o0, 0,
                  1'b1, 1'b0, 36'o3333, 4);

        // clken low for 5 clocks during WAIT
        run_check("clken_stall", 1'b0, 1'b1, 1'b0, 1'b0, 22'd5, 36'o0, 5,
                  1'b1, 1'b0, 36'o123456701234, 9);

        // clken low while the acknowledge is up freezes ack and data
        begin
            int t;
            req1 = 1'b1;
            addr1 = '0; addr1[3] = 1'b1; addr1[14:35] = 22'd7;
            t = 0;
            while (t < 12 && !ack1) begin
                tick();
                t++;
            end
            $display("txn freeze: ack after %0d clocks, data='o%0o", t, dout1);
            chk("frz_ack_seen", 36'(ack1), 36'd1);
            clken = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("frz_ack_held", 36'(ack1), 36'd1);
                chk("frz_data_held", dout1, 36'o2);
            end
            clken = 1'b1;
            tick();
            chk("frz_ack_end", 36'(ack1), 36'd0);
            req1 = 1'b0;
            tick();
        end

        // Zero wait states
        run_check("w0_write", 1'b1, 1'b0, 1'b1, 1'b0, 22'd0, 36'o17, 0,
                  1'b1, 1'b0, 36'o0, 2);
        run_check("w0_read", 1'b1, 1'b1, 1'b0, 1'b0, 22'd0, 36'o0, 0,
                  1'b1, 1'b0, 36'o17, 2);

        // Randomized traffic against the memory model
        for (int i = 0; i < 16; i++) begin
            mdl[i] = {4'($urandom), $urandom};
            run_check($sformatf("init%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 22'(i), mdl[i], 0,
                      1'b1, 1'b0, 36'o0, 4);
        end
        for (int i = 0; i < 60; i++) begin
            bit rd, wr, out_of_range;
            int a, stall;
            logic [35:0] d, e_dat;
            rd = 1'($urandom);
            wr = 1'($urandom);
            out_of_range = ($urandom_range(0, 7) == 0);
            a = out_of_range ? 1024 + int'($urandom_range(0, 3000)) : int'($urandom_range(0, 15));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            d = {4'($urandom), $urandom};
            e_dat = '0;
            if (!out_of_range) begin
                if (rd) e_dat = mdl[a];
                if (wr) mdl[a] = d;
            end
            run_check($sformatf("rnd%0d", i), 1'b0, rd, wr, 1'b0, 22'(a), d, stall,
                      !out_of_range, out_of_range, e_dat, 4 + stall);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_resp.md
# mem_resp

Main-memory responder for the KS10 backplane bus: the target end of the CPU's memory read/write cycles. It samples a bus request, decodes the cycle-type flags carried in the address word and performs the access. Serviced requests complete after a programmable number of wait states with a one-clock acknowledge and read data; out-of-range addresses complete with a non-existent-memory (NXM) indication. It sits on the bus beside the CPU and the IO bridge, and ignores IO cycles, which belong to the bridge.

## Interface

Parameters:
- memAW, 10, word-address width; memory holds 2**memAW 36-bit words.
- memWAIT, 2, wait states inserted before a response (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- clken  in  1  clock enable; every register, the state machine and the counter advance only on edges where clken=1.
- busREQI  in  1  bus request from the initiator; level, held until the acknowledge.
- busADDRI  in  [0:35]  address word. Bits [0:13] are cycle flags: bit 3 READ, bit 5 WRITE, bit 10 IO. Bits [14:35] are the address.
- busDATAI  in  [0:35]  write data; valid with busREQI.
- busACKO  out  1  acknowledge; one-clock pulse.
- busDATAO  out  [0:35]  read data; valid while busACKO=1, otherwise 0.
- busNXM  out  1  non-existent-memory pulse; one clock, replaces the acknowledge.
- nxmADDR  out  [14:35]  address of the most recent NXM cycle.
- memBUSY  out  1  high in every state except IDLE.

## Operation

- States: IDLE, WAIT, RESP, DONE.
- IDLE
  - If busREQI=1 and IO flag=0: latch flags, address [14:35] and data; load cnt=memWAIT; go to WAIT.
  - If busREQI=1 and IO flag=1: ignore the request and stay in IDLE. Nothing is driven.
- WAIT
  - cnt≠0: decrement cnt.
  - cnt=0: go to RESP.
- RESP (exactly one enabled clock), evaluated on the latched request:
  - Address valid: addr[14:35] < 2**memAW (bits above memAW-1 are all zero).
  - Valid, READ only: busDATAO=mem[addr], busACKO=1.
  - Valid, WRITE only: mem[addr]←data, busACKO=1, busDATAO=0.
  - Valid, READ and WRITE (read-modify-write): busDATAO returns the old contents; the new data is written on the same edge (read-before-write).
  - Valid, neither READ nor WRITE: busACKO=1, busDATAO=0, no write.
  - Invalid address: no access, busNXM=1, busACKO=0, nxmADDR←addr.
  - Next state: DONE.
- DONE: wait for busREQI=0, then go to IDLE. This is a four-phase handshake; a still-asserted request is never serviced twice.
- The memory array has no reset; its contents are undefined until written.
- nxmADDR holds its value until the next NXM cycle.

## Timing

- Reset (rst=0, asynchronous):
  - State=IDLE, cnt=0.
  - busACKO=0, busNXM=0, busDATAO=0, nxmADDR=0, memBUSY=0.
- Reset mid-cycle: the cycle is abandoned. A write whose RESP edge has not occurred is not performed.
- Latency, counted in enabled clocks: the request is sampled on edge E. busACKO/busNXM are high during the clock after edge E+memWAIT+1 and last exactly one enabled clock.
  - memWAIT=0 gives a response in the 2nd cycle after sampling.
- busACKO and busNXM are registered and never high together.
- memBUSY rises on edge E and falls on the edge that returns to IDLE.
- Back-to-back: the next request can be sampled no earlier than the first enabled edge after busREQI is seen low in DONE.
- clken=0 freezes everything, including the held busACKO and busDATAO levels.

## Test plan

- Write then read, memWAIT=2:
  - Write 36'o123456701234 to addr 5 -> busACKO rises 3 clocks after sampling, lasts 1 clock.
  - Read addr 5 -> busDATAO=36'o123456701234 during the acknowledge.
- Read-modify-write: addr 7 holds 36'o1.
  - Request READ+WRITE with data 36'o2 -> acknowledge returns 36'o1.
  - Subsequent read returns 36'o2.
- NXM, memAW=10: read addr 36'o2000 -> busNXM=1 for 1 clock, busACKO stays 0, nxmADDR=36'o2000, memory unchanged.
- Ignored and held requests:
  - IO-flag request -> memBUSY stays 0, no acknowledge within 20 clocks.
  - busREQI held high after an acknowledge -> exactly one acknowledge; after busREQI drops, the next request is serviced normally.
- Reset and clock enable:
  - Assert rst in WAIT for a write to addr 3 -> all outputs 0 immediately; a later read of addr 3 returns its prior value.
  - clken low for 5 clocks during WAIT -> response delayed by exactly 5 clocks.
- memWAIT=0: read addr 0 -> acknowledge in the 2nd cycle after sampling.
